apb_nslave_bridge: RTL and testbench

Parametrised APB requester that serves a single request/response port and fans out to `NUM_SLAVES` APB completers, such as `apb_s_top` RAM instances. It decodes the target slave index, runs the APB SETUP/ACCESS sequence, and muxes back the selected completer's read data and handshake. It adds three things over the fixed two-slave system: a decode error for unmapped indices, an ACCESS-phase timeout, and a saturating error counter. It sits between the test/CPU-side request logic and the APB slave array.

---
 rtl/apb_pkg.sv | 8 +
 rtl/apb_resp_mux.sv | 29 ++
 rtl/apb_nslave_bridge.sv | 103 ++++++++++
 tb/tb_apb_nslave_bridge.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared response codes, bridge FSM states and default APB widths
package apb_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int SLV_ADDR_WIDTH = 3;
  typedef enum logic [1:0] {APB_OKAY, APB_SLVERR, APB_DECERR, APB_TIMEOUT} apb_resp_e;
  typedef enum logic [1:0] {BR_IDLE, BR_SETUP, BR_ACCESS, BR_RESP} apb_br_state_e;
endpackage

// File: rtl/apb_resp_mux.sv
// apb_resp_mux: picks the indexed completer's read data and handshake, ignoring all others
module apb_resp_mux
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = apb_pkg::DATA_WIDTH,
  parameter int IDX_WIDTH  = apb_pkg::SLV_ADDR_WIDTH
) (
  input  logic [IDX_WIDTH-1:0]             idx,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             ready,
  output logic                             slverr
);
  // only the matching lane is read, so X on unselected completers never propagates
  always_comb begin
    rdata = '0;
    ready = 1'b0;
    slverr = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (int'(idx) == i) begin
        rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
        ready = pready[i];
        slverr = pslverr[i];
      end
  end
endmodule

// File: rtl/apb_nslave_bridge.sv
// apb_nslave_bridge: request/response port to N APB completers with decode error, timeout and error count
module apb_nslave_bridge
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = apb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = apb_pkg::DATA_WIDTH,
  parameter int SLV_IDX_WIDTH  = apb_pkg::SLV_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [SLV_IDX_WIDTH-1:0]         req_slv,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic                             req_write,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output apb_resp_e                        rsp_code,
  output logic [15:0]                      err_count,
  output logic [ADDR_WIDTH-1:0]            paddr,
  output logic [NUM_SLAVES-1:0]            psel,
  output logic                             penable,
  output logic                             pwrite,
  output logic [DATA_WIDTH-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]            pready,
  input  logic [NUM_SLAVES-1:0]            pslverr
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  apb_br_state_e state, state_nx;
  apb_resp_e code_nx;
  logic [SLV_IDX_WIDTH-1:0] idx;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic sel_ready, sel_err, accept, timeout;

  apb_resp_mux #(.NUM_SLAVES(NUM_SLAVES), .DATA_WIDTH(DATA_WIDTH), .IDX_WIDTH(SLV_IDX_WIDTH)) u_mux (
    .idx(idx), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rdata(sel_rdata), .ready(sel_ready), .slverr(sel_err)
  );

  assign req_ready = state == BR_IDLE && presetn;
  assign accept = req_valid && req_ready;
  assign rsp_valid = state == BR_RESP;
  assign penable = state == BR_ACCESS;
  assign psel = (state == BR_SETUP || state == BR_ACCESS) ? NUM_SLAVES'(1) << idx : '0;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);

  // state register; reset drops every strobe at once and discards any pending response
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) state <= BR_IDLE;
    else state <= state_nx;

  // next state and the response code to latch on entry to RESP
  always_comb begin
    state_nx = state;
    code_nx = APB_OKAY;
    case (state)
      BR_IDLE: if (accept) begin
        state_nx = int'(req_slv) >= NUM_SLAVES ? BR_RESP : BR_SETUP;
        code_nx = APB_DECERR;
      end
      BR_SETUP: state_nx = BR_ACCESS;
      BR_ACCESS: if (sel_ready) begin
        state_nx = BR_RESP;
        code_nx = sel_err ? APB_SLVERR : APB_OKAY;
      end else if (timeout) begin
        state_nx = BR_RESP;
        code_nx = APB_TIMEOUT;
      end
      default: state_nx = BR_IDLE;
    endcase
  end

  // request capture, access timer, response latch and saturating error counter
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      idx <= '0;
      paddr <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      cnt <= '0;
      rsp_code <= APB_OKAY;
      rsp_rdata <= '0;
      err_count <= '0;
    end else begin
      if (accept) begin
        idx <= req_slv;
        paddr <= req_addr;
        pwrite <= req_write;
        pwdata <= req_wdata;
      end
      cnt <= state == BR_ACCESS ? cnt + 1'b1 : '0;
      if (state != BR_RESP && state_nx == BR_RESP) begin
        rsp_code <= code_nx;
        rsp_rdata <= (code_nx == APB_OKAY && !pwrite) ? sel_rdata : '0;
      end
      if (rsp_valid && rsp_code != APB_OKAY && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
endmodule

// File: tb/tb_apb_nslave_bridge.sv
// tb_apb_nslave_bridge: scenario tasks plus random traffic against a memory-level reference model
module tb_apb_nslave_bridge;
  import apb_pkg::*;
  localparam int NS = 4;
  localparam int TO = 16;

  logic pclk, presetn, req_valid, req_ready, req_write, rsp_valid, penable, pwrite;
  logic [2:0] req_slv;
  logic [31:0] req_addr, req_wdata, rsp_rdata, paddr, pwdata;
  apb_resp_e rsp_code;
  logic [15:0] err_count;
  logic [NS-1:0] psel, pready, pslverr;
  logic [NS*32-1:0] prdata;

  apb_nslave_bridge #(.NUM_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV_IDX_WIDTH(3), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_ready(req_ready), .req_slv(req_slv),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_code(rsp_code), .err_count(err_count), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec, n_fail;
  int ws_cfg, acc_cnt;
  bit perr_cfg, hang_cfg, fill;
  logic [31:0] mem [NS][16];
  logic [31:0] exp_mem [NS][16];
  int exp_err;

  function automatic logic [31:0] init_word(int s, int w);
    return {8'hA5, 8'(s), 8'(w), 8'h3C};
  endfunction

  // completer array: only the selected one drives real values, the rest drive X
  always_comb begin
    pready = 'x;
    pslverr = 'x;
    prdata = 'x;
    for (int s = 0; s < NS; s++)
      if (psel[s]) begin
        pready[s] = penable && acc_cnt >= ws_cfg && !hang_cfg;
        pslverr[s] = perr_cfg;
        prdata[s*32 +: 32] = mem[s][paddr[5:2]];
      end
  end

  // completer storage and wait-state timer
  always @(posedge pclk) begin
    acc_cnt <= penable ? acc_cnt + 1 : 0;
    if (fill) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < 16; w++) mem[s][w] <= init_word(s, w);
    end else
      for (int s = 0; s < NS; s++)
        if (psel[s] && penable && pready[s] && !pslverr[s] && pwrite) mem[s][paddr[5:2]] <= pwdata;
  end

  task automatic do_txn(input int slv, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input int ws, input bit perr, input bit hang, input string tag);
    bit dec = slv >= NS;
    int lat;
    apb_resp_e code;
    logic [31:0] rd = 32'h0;
    logic [NS-1:0] oh = dec ? '0 : NS'(1) << slv;
    logic [NS-1:0] exp_sel;
    if (dec) begin lat = 1; code = APB_DECERR; end
    else if (hang) begin lat = 2 + TO; code = APB_TIMEOUT; end
    else begin
      lat = 3 + ws;
      code = perr ? APB_SLVERR : APB_OKAY;
      if (!perr && !wr) rd = exp_mem[slv][addr[5:2]];
      if (!perr && wr) exp_mem[slv][addr[5:2]] = wd;
    end
    @(negedge pclk);
    req_valid = 1'b1; req_slv = 3'(slv); req_addr = addr; req_write = wr; req_wdata = wd;
    ws_cfg = ws; perr_cfg = perr; hang_cfg = hang;
    n_vec++;
    if (req_ready !== 1'b1 || err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL %s idle: req_ready=%b err_count=%0d, need 1 and %0d", tag, req_ready, err_count, exp_err);
    end
    @(posedge pclk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge pclk);
      if (k == 1) begin
        req_valid = $urandom_range(0, 1); req_slv = 3'($urandom); req_addr = $urandom;
        req_write = $urandom_range(0, 1); req_wdata = $urandom;
      end
      exp_sel = (k < lat && !dec) ? oh : '0;
      n_vec++;
      if (psel !== exp_sel || penable !== (k >= 2 && k < lat && !dec) || rsp_valid !== (k == lat) || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s cyc%0d: psel=%b en=%b rv=%b rdy=%b, need psel=%b en=%b rv=%b rdy=0", tag, k, psel, penable,
                 rsp_valid, req_ready, exp_sel, (k >= 2 && k < lat && !dec), (k == lat));
      end
      if (exp_sel != '0) begin
        n_vec++;
        if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wd)) begin
          n_fail++;
          $display("FAIL %s apb cyc%0d: paddr=%h pwrite=%b pwdata=%h, need %h %b %h", tag, k, paddr, pwrite, pwdata, addr, wr, wd);
        end
      end
      if (k == lat) begin
        n_vec++;
        if (rsp_code !== code || rsp_rdata !== rd) begin
          n_fail++;
          $display("FAIL %s rsp: code=%0d rdata=%h, need code=%0d rdata=%h", tag, rsp_code, rsp_rdata, code, rd);
        end
      end
    end
    req_valid = 1'b0;
    if (code != APB_OKAY && exp_err < 16'hFFFF) exp_err++;
  endtask

  task automatic test_reset();
    presetn = 1'b0; fill = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge pclk);
    #1 fill = 1'b0;
    n_vec++;
    if (req_ready !== 1'b0 || psel !== '0 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0 ||
        rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_code !== APB_OKAY || err_count !== '0) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b psel=%b en=%b pw=%b pa=%h pwd=%h rv=%b rd=%h code=%0d ec=%0d, need all 0",
               req_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_code, err_count);
    end
    @(negedge pclk) presetn = 1'b1;
    @(negedge pclk);
    n_vec++;
    if (req_ready !== 1'b1 || psel !== '0) begin
      n_fail++;
      $display("FAIL reset_release: req_ready=%b psel=%b, need 1 and 0", req_ready, psel);
    end
  endtask

  task automatic test_write_zero_wait();
    do_txn(2, 32'h10, 1'b1, 32'hDEADBEEF, 0, 1'b0, 1'b0, "write_zero_wait");
  endtask

  task automatic test_read_wait();
    do_txn(2, 32'h10, 1'b0, 32'h0, 3, 1'b0, 1'b0, "read_wait3");
  endtask

  task automatic test_decerr();
    do_txn(5, 32'h20, 1'b0, 32'h0, 0, 1'b0, 1'b0, "decerr");
    do_txn(1, 32'h4, 1'b0, 32'h0, 0, 1'b0, 1'b0, "after_decerr");
  endtask

  task automatic test_timeout();
    do_txn(1, 32'h8, 1'b1, 32'h12345678, 0, 1'b0, 1'b1, "timeout");
    do_txn(1, 32'h8, 1'b0, 32'h0, 1, 1'b0, 1'b0, "after_timeout");
  endtask

  task automatic test_slverr_then_okay();
    do_txn(3, 32'h30, 1'b0, 32'h0, 1, 1'b1, 1'b0, "slverr_read");
    do_txn(3, 32'h30, 1'b1, 32'hCAFEF00D, 0, 1'b0, 1'b0, "back_to_back");
    do_txn(3, 32'h30, 1'b0, 32'h0, 0, 1'b0, 1'b0, "back_to_back_rd");
  endtask

  task automatic test_reset_mid();
    @(negedge pclk);
    req_valid = 1'b1; req_slv = 3'd0; req_addr = 32'h0; req_write = 1'b0; req_wdata = 32'h0;
    ws_cfg = 6; perr_cfg = 1'b0; hang_cfg = 1'b0;
    @(posedge pclk);
    repeat (3) @(negedge pclk);
    req_valid = 1'b0;
    n_vec++;
    if (penable !== 1'b1 || psel !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_reset_pre: penable=%b psel=%b, need 1 and 0001", penable, psel);
    end
    #2 presetn = 1'b0;
    #1;
    n_vec++;
    if (psel !== '0 || penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || err_count !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: psel=%b en=%b rv=%b rdy=%b ec=%0d, need all 0", psel, penable, rsp_valid, req_ready, err_count);
    end
    exp_err = 0;
    @(negedge pclk) presetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk);
      n_vec++;
      if (rsp_valid !== 1'b0 || psel !== '0) begin
        n_fail++;
        $display("FAIL mid_reset_quiet cyc%0d: rsp_valid=%b psel=%b, need 0", k, rsp_valid, psel);
      end
    end
    do_txn(0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0, "after_mid_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 150; t++)
      do_txn($urandom_range(0, 5), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0, "random");
  endtask

  initial begin
    n_vec = 0; n_fail = 0; exp_err = 0;
    ws_cfg = 0; perr_cfg = 1'b0; hang_cfg = 1'b0; acc_cnt = 0;
    req_slv = '0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 16; w++) exp_mem[s][w] = init_word(s, w);
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_decerr();
    test_timeout();
    test_slverr_then_okay();
    test_reset_mid();
    test_random();
    @(negedge pclk);
    n_vec++;
    if (err_count !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL final_err_count: err_count=%0d, need %0d", err_count, exp_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
